// File: rtl/main_fsm.sv
// Moore main FSM of the multi-cycle RV32I controller: fetch/decode/execute/memory/writeback sequencing.
// Optional trap on unknown opcodes is built when MAIN_FSM_ILLEGAL_TRAP_EN is defined.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       Branch,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       AdrSrc,
  output logic [1:0] ALUOp,
  output logic       instr_retired,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd12
`endif
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_LUI, S_JAL: state_d = S_ALUWB;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs; reset gates everything to zero regardless of state
  always_comb begin
    Branch        = 1'b0;
    PCUpdate      = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    AdrSrc        = 1'b0;
    ALUOp         = 2'b00;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCUpdate  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        MemWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      S_ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA       = 2'b10;
        ALUOp         = 2'b01;
        Branch        = 1'b1;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      S_TRAP: illegal_instr = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      Branch        = 1'b0;
      PCUpdate      = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      AdrSrc        = 1'b0;
      ALUOp         = 2'b00;
      instr_retired = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-cycle expected output vectors are queued with their stimulus
// and compared against the DUT at each falling edge.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc, instr_retired, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

  int errors = 0;
  int checks = 0;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op),
    .Branch(Branch), .PCUpdate(PCUpdate), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .AdrSrc(AdrSrc), .ALUOp(ALUOp), .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  opv;
    logic [15:0] exp;
    string       tag;
  } step_t;

  step_t sb_q[$];

  logic [15:0] obs;
  assign obs = {Branch, PCUpdate, RegWrite, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                AdrSrc, ALUOp, instr_retired, illegal_instr};

  function automatic logic [15:0] mk(input logic br, input logic pcu, input logic rw,
                                     input logic mw, input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb, input logic adr,
                                     input logic [1:0] aop, input logic ret, input logic ill);
    return {br, pcu, rw, mw, irw, rs, sa, sb, adr, aop, ret, ill};
  endfunction

  logic [15:0] E_ZERO, E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE;
  logic [15:0] E_EXR, E_EXI, E_LUI, E_ALUWB, E_BEQ, E_JAL, E_TRAP;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  task automatic push(input logic r, input logic [6:0] o, input logic [15:0] e, input string t);
    step_t s;
    s.rst = r; s.opv = o; s.exp = e; s.tag = t;
    sb_q.push_back(s);
  endtask

  // Drive each queued step just after a rising edge, check at the following falling edge
  task automatic drain();
    step_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      @(posedge clk);
      #1;
      reset = s.rst;
      op    = s.opv;
      @(negedge clk);
      checks++;
      assert (obs === s.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", s.tag, obs, s.exp);
      end
    end
  endtask

  initial begin
    E_ZERO     = '0;
    E_FETCH    = mk(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0, 0);
    E_DECODE   = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, 0);
    E_MEMADR   = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, 0);
    E_MEMREAD  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0);
    E_MEMWB    = mk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 1, 0);
    E_MEMWRITE = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 0);
    E_EXR      = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0, 0);
    E_EXI      = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0, 0);
    E_LUI      = mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, 2'b11, 0, 0);
    E_ALUWB    = mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0);
    E_BEQ      = mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 1, 0);
    E_JAL      = mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0, 0);
    E_TRAP     = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1);

    push(1, OP_LW, E_ZERO, "reset_c1");
    push(1, OP_LW, E_ZERO, "reset_c2");
    push(0, OP_LW, E_FETCH,   "lw_fetch");
    push(0, OP_LW, E_DECODE,  "lw_decode");
    push(0, OP_LW, E_MEMADR,  "lw_memadr");
    push(0, OP_LW, E_MEMREAD, "lw_memread");
    push(0, OP_LW, E_MEMWB,   "lw_memwb");
    push(0, OP_SW, E_FETCH,    "sw_fetch");
    push(0, OP_SW, E_DECODE,   "sw_decode");
    push(0, OP_SW, E_MEMADR,   "sw_memadr");
    push(0, OP_SW, E_MEMWRITE, "sw_memwrite");
    push(0, OP_R, E_FETCH,  "r_fetch");
    push(0, OP_R, E_DECODE, "r_decode");
    push(0, OP_R, E_EXR,    "r_execute");
    push(0, OP_R, E_ALUWB,  "r_aluwb");
    push(0, OP_I, E_FETCH,  "i_fetch");
    push(0, OP_I, E_DECODE, "i_decode");
    push(0, OP_I, E_EXI,    "i_execute");
    push(0, OP_I, E_ALUWB,  "i_aluwb");
    push(0, OP_BEQ, E_FETCH,  "beq_fetch");
    push(0, OP_BEQ, E_DECODE, "beq_decode");
    push(0, OP_BEQ, E_BEQ,    "beq_branch");
    push(0, OP_JAL, E_FETCH,  "jal_fetch");
    push(0, OP_JAL, E_DECODE, "jal_decode");
    push(0, OP_JAL, E_JAL,    "jal_jump");
    push(0, OP_JAL, E_ALUWB,  "jal_aluwb");
    push(0, OP_LUI, E_FETCH,  "lui_fetch");
    push(0, OP_LUI, E_DECODE, "lui_decode");
    push(0, OP_LUI, E_LUI,    "lui_exec");
    push(0, OP_LUI, E_ALUWB,  "lui_aluwb");
    drain();

    // Reset asserted during MEMREAD of a load aborts it
    push(0, OP_LW, E_FETCH,  "abort_fetch");
    push(0, OP_LW, E_DECODE, "abort_decode");
    push(0, OP_LW, E_MEMADR, "abort_memadr");
    push(1, OP_LW, E_ZERO,   "abort_reset_in_memread");
    push(0, OP_LW, E_FETCH,  "abort_post_reset_fetch");
    push(0, OP_LW, E_DECODE, "abort_relw_decode");
    push(0, OP_LW, E_MEMADR, "abort_relw_memadr");
    push(0, OP_LW, E_MEMREAD, "abort_relw_memread");
    push(0, OP_LW, E_MEMWB,  "abort_relw_memwb");
    drain();

    push(0, OP_BAD, E_FETCH,  "bad_fetch");
    push(0, OP_BAD, E_DECODE, "bad_decode");
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    push(0, OP_LW, E_TRAP, "trap_c1");
    push(0, OP_LW, E_TRAP, "trap_c2");
    push(0, OP_R,  E_TRAP, "trap_held");
    push(1, OP_R,  E_ZERO, "trap_reset");
`endif
    push(0, OP_BEQ, E_FETCH,  "after_bad_fetch");
    push(0, OP_BEQ, E_DECODE, "after_bad_decode");
    push(0, OP_BEQ, E_BEQ,    "after_bad_beq");
    push(0, OP_BEQ, E_FETCH,  "final_fetch");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
